// File: rtl/shifter_pkg.sv
// ----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined shifter/rotator.
//   OP_ROL / OP_SLL / OP_ROR / OP_SRL : 2-bit operation encodings
//   log2()                            : constant function sizing the count
//                                       field and the number of stages
// ----------------------------------------------------------------------------
package shifter_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // Ceiling log2; exact for the power-of-two widths this block supports.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// ----------------------------------------------------------------------------
// shifter_stage
// One registered stage of the shifter pipeline. Shifts or rotates the
// upstream word by 2^STAGE when count bit STAGE is set, otherwise passes it
// through. Count, op and tag travel with the data unchanged.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   adv_i           : this stage loads from upstream on this edge
//   up_*_i          : upstream valid/data/cnt/op/tag
//   valid_o..tag_o  : registered stage contents
//   zero_o          : registered "data_o == 0" flag
// ----------------------------------------------------------------------------
module shifter_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  parameter  int STAGE = 0,
  localparam int CW    = log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [CW-1:0]    up_cnt_i,
  input  logic [1:0]       up_op_i,
  input  logic [TAG_W-1:0] up_tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    cnt_o,
  output logic [1:0]       op_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             zero_o
);

  localparam int DIST = 1 << STAGE;

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             zero_q, zero_d;

  always_comb begin
    data_d = up_data_i;
    if (up_cnt_i[STAGE]) begin
      case (up_op_i)
        OP_ROL:  data_d = (up_data_i << DIST) | (up_data_i >> (WIDTH - DIST));
        OP_SLL:  data_d = up_data_i << DIST;
        OP_ROR:  data_d = (up_data_i >> DIST) | (up_data_i << (WIDTH - DIST));
        OP_SRL:  data_d = up_data_i >> DIST;
        default: data_d = up_data_i;
      endcase
    end
    zero_d = (data_d == '0);
  end

  // Payload only loads with a valid operation, so a stalled or drained stage
  // keeps showing its last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_ROL;
      tag_q   <= '0;
      zero_q  <= 1'b1;
    end else if (adv_i) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        data_q <= data_d;
        cnt_q  <= up_cnt_i;
        op_q   <= up_op_i;
        tag_q  <= up_tag_i;
        zero_q <= zero_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
  assign op_o    = op_q;
  assign tag_o   = tag_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/shifter_pipe.sv
// ----------------------------------------------------------------------------
// shifter_pipe
// CW-stage pipelined barrel shifter/rotator (CW = log2(WIDTH)). Stage k
// handles count bit k, so bit 0 is applied first. One operation per cycle,
// CW cycles of latency, results in input order.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : input handshake
//   in_data/in_cnt/in_op/in_tag: operand, amount, op (00 ROL 01 SLL 10 ROR
//                                11 SRL), sideband tag
//   out_valid/out_ready        : output handshake
//   out_data/out_tag/out_zero  : result, its tag, registered zero flag
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same interface. Producers hold valid and payload until the
// transfer; in_ready may depend combinationally on out_ready.
// ----------------------------------------------------------------------------
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  localparam int CW    = log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_cnt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  // Index 0 is the input port, index k+1 is the output of stage k.
  logic [CW:0]      v;
  logic [WIDTH-1:0] d [CW+1];
  logic [CW-1:0]    c [CW+1];
  logic [1:0]       o [CW+1];
  logic [TAG_W-1:0] t [CW+1];
  logic [CW-1:0]    z;
  logic [CW-1:0]    adv;

  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign c[0] = in_cnt;
  assign o[0] = in_op;
  assign t[0] = in_tag;

  // A stage advances when it is empty or the stage after it advances; the
  // last stage looks at out_ready. This chain is what lets a full pipeline
  // accept and emit in the same cycle.
  always_comb begin
    adv = '0;
    adv[CW-1] = !v[CW] || out_ready;
    for (int k = CW - 2; k >= 0; k--) begin
      adv[k] = !v[k+1] || adv[k+1];
    end
  end

  for (genvar k = 0; k < CW; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STAGE (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv_i      (adv[k]),
      .up_valid_i (v[k]),
      .up_data_i  (d[k]),
      .up_cnt_i   (c[k]),
      .up_op_i    (o[k]),
      .up_tag_i   (t[k]),
      .valid_o    (v[k+1]),
      .data_o     (d[k+1]),
      .cnt_o      (c[k+1]),
      .op_o       (o[k+1]),
      .tag_o      (t[k+1]),
      .zero_o     (z[k])
    );
  end

  // Count/op of the final stage and zero flags of inner stages have no
  // consumer at the boundary.
  logic unused_tail;
  assign unused_tail = ^{c[CW], o[CW], z[CW-2:0]};

  assign in_ready  = rst_n && adv[0];
  assign out_valid = v[CW];
  assign out_data  = d[CW];
  assign out_tag   = t[CW];
  assign out_zero  = z[CW-1];

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width; SHALL be a power of two, 4..64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 Derived constant CW = log2(WIDTH) SHALL size cnt and SHALL set the number of stages.
REQ-004 Ports, in order:
- clk  in  1  single rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  WIDTH  operand.
- in_cnt  in  CW  shift/rotate amount.
- in_op  in  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  out_data == 0.

Function
REQ-005 The block SHALL be a CW-stage pipeline; stage k SHALL shift or rotate by 2^k when cnt bit k of its operation is 1, and pass the data through otherwise; bit 0 is applied first.
REQ-006 ROL/ROR SHALL wrap the bits that leave the word; SLL/SRL SHALL fill vacated bits with 0.
REQ-007 Each stage SHALL hold one valid bit, data, cnt, op and tag; op, cnt and tag SHALL travel unchanged with the data.
REQ-008 A transfer SHALL occur on a rising clk edge when valid and ready are both 1 at the same interface.
REQ-009 Stage k SHALL advance when it is empty or when stage k+1 advances; the last stage SHALL advance when it is empty or out_ready is 1.
REQ-010 in_ready SHALL equal the stage-0 advance condition; in_ready is allowed a combinational path from out_ready.
REQ-011 Latency SHALL be CW cycles from input transfer to out_valid when there is no stall; throughput SHALL be one operation per cycle.
REQ-012 Results SHALL leave the block in input order; none SHALL be dropped or duplicated.
REQ-013 When the pipeline is full and out_ready is 0, the block SHALL hold all state, deassert in_ready, and keep out_data, out_tag and out_zero stable.
REQ-014 When a full pipeline sees out_ready = 1 and in_valid = 1 in the same cycle, the block SHALL emit one result and accept one new input in that cycle.
REQ-015 in_cnt = 0 SHALL return in_data unchanged for every op.
REQ-016 out_zero SHALL be registered together with the last stage's data, not computed after the output.
REQ-017 The block SHALL sample in_data, in_cnt, in_op and in_tag only on an input transfer; when in_valid is 0 they are don't-care.

Reset
REQ-018 While rst_n = 0 at a clk edge, every stage valid bit SHALL clear, and every data and tag register SHALL clear to 0.
REQ-019 Output values during and after reset:
- out_valid SHALL be 0 and in_ready SHALL be 0 while rst_n = 0.
- out_data, out_tag and out_zero SHALL read 0, 0 and 1 after reset.
- in_ready SHALL be 1 on the first cycle after rst_n returns to 1.
REQ-020 Reset asserted mid-operation SHALL discard every in-flight operation; none SHALL appear after reset.

Structure
REQ-021 Shared package shifter_pkg SHALL hold:
- the op encoding constants OP_ROL, OP_SLL, OP_ROR, OP_SRL;
- a log2 constant function used for CW.
REQ-022 Sub-module shifter_stage SHALL implement one registered stage, with parameters WIDTH, TAG_W and STAGE (shift distance 2^STAGE); shifter_pipe SHALL instantiate CW of them through a generate loop.

Verification
REQ-023 Directed scenarios, WIDTH=16; the bench SHALL cover all five:
- ROL 0x8001 cnt 1 -> 0x0003 after 4 cycles, tag preserved.
- SLL 0x8001 cnt 4 -> 0x0010; ROR 0x0001 cnt 1 -> 0x8000; SRL 0xF000 cnt 12 -> 0x000F; SRL 0x0001 cnt 1 -> 0x0000 with out_zero=1.
- out_ready held 0, issue tags 1..5 -> exactly 4 accepted, in_ready=0; then out_ready=1 -> tags 1..5 emerge in order on consecutive cycles.
- Back-to-back 16 random ops with out_ready toggling each cycle -> every result matches a reference model, in order, no loss.
- Pipeline full, rst_n pulsed low 1 cycle -> out_valid=0 next cycle, no stale results afterward, in_ready=1.
